// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port arbiter.
// The arbiter binds the slave modport; the pipeline/memory environment binds master.
interface mem_port_arbiter_if;
  // Fetch path
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        stall_if;

  // Data (MEM-stage) path
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        stall_mem;

  // Single-port memory
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  // Handshake: a requester raises *_req with address/data stable at the grant
  // edge and holds it until its one-cycle *_done pulse; it drops req at the
  // edge after done, and never changes req while an access is in flight.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, stall_if, d_done, d_rdata, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, stall_if, d_done, d_rdata, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Optional performance counters are enabled with the ARB_PERF_CNT_EN macro.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_port_arbiter_if.slave      bus,
  output logic [1:0]             dbg_state_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_if_wait,
  output logic [31:0]            perf_d_wait,
  output logic [31:0]            perf_conflict
`endif
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_INIT   = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2
  } owner_e;

  state_e         state_q,     state_d;
  owner_e         owner_q,     owner_d;
  logic [3:0]     lat_cnt_q,   lat_cnt_d;
  logic [SW-1:0]  starve_q,    starve_d;
  logic           we_q,        we_d;
  logic           mem_en_q,    mem_en_d;
  logic           mem_we_q,    mem_we_d;
  logic [63:0]    mem_addr_q,  mem_addr_d;
  logic [63:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]    if_rdata_q,  if_rdata_d;
  logic [63:0]    d_rdata_q,   d_rdata_d;

  logic grant_data;
  logic grant_fetch;
  logic if_done;
  logic d_done;

  // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
  assign grant_data  = bus.d_req && (!bus.if_req || (starve_q < STARVE_LIM));
  assign grant_fetch = !grant_data && bus.if_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d     = ST_ACCESS;
          owner_d     = OWN_DATA;
          we_d        = bus.d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          lat_cnt_d   = LAT_INIT;
          if (!bus.if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (grant_fetch) begin
          state_d    = ST_ACCESS;
          owner_d    = OWN_FETCH;
          we_d       = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = bus.if_addr;
          lat_cnt_d  = LAT_INIT;
          starve_d   = '0;
        end
      end

      ST_ACCESS: begin
        // lat_cnt hits zero in the cycle mem_rdata becomes valid.
        if (lat_cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = bus.mem_rdata[31:0];
          end else if (!we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign if_done = (state_q == ST_DONE) && (owner_q == OWN_FETCH);
  assign d_done  = (state_q == ST_DONE) && (owner_q == OWN_DATA);

  assign bus.if_done   = if_done;
  assign bus.d_done    = d_done;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  // Stalls are forced low while reset is held so every output reads zero.
  assign bus.stall_if  = reset && bus.if_req && !if_done;
  assign bus.stall_mem = reset && bus.d_req && !d_done;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait_q,  perf_if_wait_d;
  logic [31:0] perf_d_wait_q,   perf_d_wait_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_if_wait_d  = perf_if_wait_q;
    perf_d_wait_d   = perf_d_wait_q;
    perf_conflict_d = perf_conflict_q;
    if (bus.stall_if && (perf_if_wait_q != 32'hFFFF_FFFF)) begin
      perf_if_wait_d = perf_if_wait_q + 32'd1;
    end
    if (bus.stall_mem && (perf_d_wait_q != 32'hFFFF_FFFF)) begin
      perf_d_wait_d = perf_d_wait_q + 32'd1;
    end
    if ((state_q == ST_IDLE) && bus.if_req && bus.d_req &&
        (perf_conflict_q != 32'hFFFF_FFFF)) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_wait_q  <= '0;
      perf_d_wait_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_if_wait_q  <= perf_if_wait_d;
      perf_d_wait_q   <= perf_d_wait_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_if_wait  = perf_if_wait_q;
  assign perf_d_wait   = perf_d_wait_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, load/fetch conflict,
// store, starvation guard and reset abandoning an access.
module tb_mem_port_arbiter;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_d_wait, perf_conflict;
`endif

  int tests = 0;
  int fails = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_wait  (perf_if_wait),
    .perf_d_wait   (perf_d_wait),
    .perf_conflict (perf_conflict)
`endif
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- memory model: fixed read contents, data returned MEM_LAT cycles after mem_en ----
  function automatic logic [63:0] rd_model(input logic [63:0] a);
    case (a)
      64'h10:  rd_model = 64'hABCD_1234_0050_0093;
      64'h100: rd_model = 64'h0000_0000_0000_0005;
      default: rd_model = 64'h0;
    endcase
  endfunction

  logic [63:0] rd_pipe [MEM_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? rd_model(bus.mem_addr) : 64'h0;
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [63:0] grant_addr [6];

  initial begin
    grant_addr[0] = 64'h100; grant_addr[1] = 64'h100; grant_addr[2] = 64'h100;
    grant_addr[3] = 64'h100; grant_addr[4] = 64'h10;  grant_addr[5] = 64'h100;

    // Reset held with both requests raised: nothing may issue.
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 64'h10;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h100; bus.d_wdata = 64'h0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_mem_en", bus.mem_en, 0);
    end
    check("rst_if_done", bus.if_done, 0);
    check("rst_d_done", bus.d_done, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_state", dbg_state, 0);

    // Release: this cycle is the IDLE decision with both requests; data wins.
    reset = 1'b1;
    #1;
    check("conf_c0_stall_mem", bus.stall_mem, 1);
    check("conf_c0_stall_if", bus.stall_if, 1);
    step();
    check("conf_c1_mem_en", bus.mem_en, 1);
    check("conf_c1_mem_addr", bus.mem_addr, 64'h100);
    check("conf_c1_mem_we", bus.mem_we, 0);
    steps(2);
    check("conf_c3_d_done", bus.d_done, 0);
    step();
    check("conf_c4_d_done", bus.d_done, 1);
    check("conf_c4_d_rdata", bus.d_rdata, 64'h5);
    check("conf_c4_if_done", bus.if_done, 0);
    check("conf_c4_stall_mem", bus.stall_mem, 0);
    bus.d_req = 1'b0;
    step();
    check("conf_c5_d_done", bus.d_done, 0);
    check("conf_c5_mem_en", bus.mem_en, 0);
    step();
    check("conf_c6_mem_en", bus.mem_en, 1);
    check("conf_c6_mem_addr", bus.mem_addr, 64'h10);
    steps(3);
    check("conf_c9_if_done", bus.if_done, 1);
    check("conf_c9_if_rdata", bus.if_rdata, 64'h0050_0093);
    check("conf_c9_d_rdata_held", bus.d_rdata, 64'h5);
    bus.if_req = 1'b0;
    step();
    check("conf_c10_if_done", bus.if_done, 0);
    check("conf_c10_if_rdata_held", bus.if_rdata, 64'h0050_0093);

    // Fetch only.
    bus.if_req = 1'b1; bus.if_addr = 64'h10;
    #1;
    check("fetch_c0_stall_if", bus.stall_if, 1);
    step();
    check("fetch_c1_mem_en", bus.mem_en, 1);
    check("fetch_c1_mem_addr", bus.mem_addr, 64'h10);
    check("fetch_c1_stall_if", bus.stall_if, 1);
    step();
    check("fetch_c2_mem_en", bus.mem_en, 0);
    step();
    check("fetch_c3_stall_if", bus.stall_if, 1);
    check("fetch_c3_if_done", bus.if_done, 0);
    step();
    check("fetch_c4_if_done", bus.if_done, 1);
    check("fetch_c4_if_rdata", bus.if_rdata, 64'h0050_0093);
    check("fetch_c4_stall_if", bus.stall_if, 0);
    bus.if_req = 1'b0;
    step();

    // Store; addr/data changed after the grant must not matter.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h20; bus.d_wdata = 64'hDEADBEEF;
    step();
    check("st_c1_mem_en", bus.mem_en, 1);
    check("st_c1_mem_we", bus.mem_we, 1);
    check("st_c1_mem_addr", bus.mem_addr, 64'h20);
    check("st_c1_mem_wdata", bus.mem_wdata, 64'hDEADBEEF);
    bus.d_addr = 64'h40; bus.d_wdata = 64'h1234;
    step();
    check("st_c2_mem_en", bus.mem_en, 0);
    check("st_c2_mem_we", bus.mem_we, 0);
    steps(2);
    check("st_c4_d_done", bus.d_done, 1);
    check("st_c4_d_rdata_kept", bus.d_rdata, 64'h5);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step();
    check("st_c5_d_done", bus.d_done, 0);

    // Both held continuously: D,D,D,D,F,D.
    bus.d_req = 1'b1; bus.d_addr = 64'h100; bus.if_req = 1'b1; bus.if_addr = 64'h10;
    for (int g = 0; g < 6; g++) begin
      step();
      check($sformatf("starve_g%0d_mem_en", g), bus.mem_en, 1);
      check($sformatf("starve_g%0d_mem_addr", g), bus.mem_addr, grant_addr[g]);
      steps(3);
      check($sformatf("starve_g%0d_if_done", g), bus.if_done, (g == 4) ? 1 : 0);
      check($sformatf("starve_g%0d_d_done", g), bus.d_done, (g == 4) ? 0 : 1);
      step();
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    step();
    check("starve_end_state", dbg_state, 0);

    // Reset during a fetch access abandons it; fetch reissues after release.
    bus.if_req = 1'b1; bus.if_addr = 64'h10;
    step();
    check("rma_c1_mem_en", bus.mem_en, 1);
    step();
    reset = 1'b0;
    #1;
    check("rma_c2_mem_en", bus.mem_en, 0);
    check("rma_c2_state", dbg_state, 0);
    check("rma_c2_mem_addr", bus.mem_addr, 0);
    steps(2);
    check("rma_c4_if_done", bus.if_done, 0);
    check("rma_c4_if_rdata", bus.if_rdata, 0);
    reset = 1'b1;
    step();
    check("rma_r1_mem_en", bus.mem_en, 1);
    check("rma_r1_mem_addr", bus.mem_addr, 64'h10);
    steps(2);
    check("rma_r3_if_done", bus.if_done, 0);
    step();
    check("rma_r4_if_done", bus.if_done, 1);
    check("rma_r4_if_rdata", bus.if_rdata, 64'h0050_0093);
    bus.if_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
